// File: rtl/mem_accum_engine.sv
// Accumulate-over-memory engine: sums Length RAM words from BaseAddr, writing the total (Mode 0) or in-place prefix sums (Mode 1).
// Optional build macro MEM_ACCUM_SATURATE_EN selects unsigned saturating accumulation instead of modulo wrap.
module mem_accum_engine #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Mode,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [ADDR_W-1:0] DestAddr,
  input  logic [ADDR_W:0]   Length,
  output logic [ADDR_W-1:0] Address,
  output logic              ReadEnable,
  output logic              WriteEnable,
  output logic [DATA_W-1:0] DataIN,
  input  logic [DATA_W-1:0] DataOut,
  output logic [DATA_W-1:0] Result,
  output logic              Overflow,
  output logic              Busy,
  output logic              Ready,
  output logic [2:0]        fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_nx;

  localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W+1)'(1);

  logic              mode_q;
  logic [ADDR_W-1:0] base_q, dest_q;
  logic [ADDR_W:0]   len_q, idx;
  logic [DATA_W-1:0] acc, acc_sum;
  logic [DATA_W:0]   sum_full;
  logic              carry;
  logic [1:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_hold, src_addr;
  logic [DATA_W-1:0] data_hold;
  logic              accept, wait_last, last_elem;

  // Start/Ready handshake: Start is a request taken only while idle or done and not
  // busy; Ready rises one cycle after the FSM reaches DONE and stays until the next accept.
  assign accept    = Start && !Busy && (state == S_IDLE || state == S_DONE);
  assign wait_last = (wait_cnt == 2'(RD_LAT - 1));
  assign last_elem = ((idx + IDX_ONE) >= len_q);
  assign src_addr  = base_q + idx[ADDR_W-1:0];
  assign sum_full  = {1'b0, acc} + {1'b0, DataOut};
  assign carry     = sum_full[DATA_W];
  assign fsm_state = state;

`ifdef MEM_ACCUM_SATURATE_EN
  assign acc_sum = carry ? {DATA_W{1'b1}} : sum_full[DATA_W-1:0];
`else
  assign acc_sum = sum_full[DATA_W-1:0];
`endif

  always_ff @(posedge Clock) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    ReadEnable  = 1'b0;
    WriteEnable = 1'b0;
    Address     = addr_hold;
    DataIN      = data_hold;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) state_nx = (Length == '0) ? S_DONE : S_READ;
      end
      S_READ: begin
        ReadEnable = 1'b1;
        Address    = src_addr;
        state_nx   = S_WAIT;
      end
      S_WAIT: begin
        if (wait_last) state_nx = (mode_q || last_elem) ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        WriteEnable = 1'b1;
        Address     = mode_q ? src_addr : dest_q;
        DataIN      = acc;
        state_nx    = (mode_q && !last_elem) ? S_READ : S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      mode_q    <= 1'b0;
      base_q    <= '0;
      dest_q    <= '0;
      len_q     <= '0;
      idx       <= '0;
      acc       <= '0;
      wait_cnt  <= '0;
      Overflow  <= 1'b0;
      Busy      <= 1'b0;
      Ready     <= 1'b0;
      Result    <= '0;
      addr_hold <= '0;
      data_hold <= '0;
    end else begin
      if (accept) begin
        mode_q   <= Mode;
        base_q   <= BaseAddr;
        dest_q   <= DestAddr;
        len_q    <= Length;
        idx      <= '0;
        acc      <= '0;
        wait_cnt <= '0;
        Overflow <= 1'b0;
        Busy     <= 1'b1;
        Ready    <= 1'b0;
      end else if (state == S_DONE && Busy) begin
        Busy   <= 1'b0;
        Ready  <= 1'b1;
        Result <= acc;
      end
      case (state)
        S_READ: addr_hold <= src_addr;
        S_WAIT: begin
          if (wait_last) begin
            wait_cnt <= '0;
            acc      <= acc_sum;
            if (carry) Overflow <= 1'b1;
            if (!mode_q && !last_elem) idx <= idx + IDX_ONE;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        S_WRITE: begin
          // Address/DataIN keep the last written location visible once idle.
          addr_hold <= Address;
          data_hold <= acc;
          if (mode_q) idx <= idx + IDX_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_accum_engine.sv
// Bench for mem_accum_engine: two instances (RD_LAT=1 and RD_LAT=2) run identical jobs against
// behavioural RAMs; expected sums, writes and latencies come from a plain-arithmetic model.
module tb_mem_accum_engine;
  localparam int DW    = 16;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int BOUND = 200;

  logic clk = 1'b0;
  logic rst_n, start, mode, load_req;
  logic [AW-1:0] base, dest;
  logic [AW:0]   len;
  logic [1:0] rden, wren, ovf, busy, ready;
  logic [1:0][AW-1:0] addr;
  logic [1:0][DW-1:0] wdata, q, result;
  logic [1:0][2:0]    st;
  logic [DW-1:0] ram0 [DEPTH];
  logic [DW-1:0] ram1 [DEPTH];
  logic [DW-1:0] pre  [DEPTH];
  logic [DW-1:0] mdl  [DEPTH];
  logic [DW-1:0] stage1;
  logic [AW+DW-1:0] exp_q0[$];
  logic [AW+DW-1:0] exp_q1[$];
  int rd_cnt [2];
  int wr_cnt [2];
  int checks   = 0;
  int failures = 0;

  // clock / reset block
  always #5 clk = ~clk;

  mem_accum_engine #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) u_dut_l1 (
    .Clock(clk), .Reset(rst_n), .Start(start), .Mode(mode),
    .BaseAddr(base), .DestAddr(dest), .Length(len),
    .Address(addr[0]), .ReadEnable(rden[0]), .WriteEnable(wren[0]),
    .DataIN(wdata[0]), .DataOut(q[0]), .Result(result[0]),
    .Overflow(ovf[0]), .Busy(busy[0]), .Ready(ready[0]), .fsm_state(st[0])
  );

  mem_accum_engine #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2)) u_dut_l2 (
    .Clock(clk), .Reset(rst_n), .Start(start), .Mode(mode),
    .BaseAddr(base), .DestAddr(dest), .Length(len),
    .Address(addr[1]), .ReadEnable(rden[1]), .WriteEnable(wren[1]),
    .DataIN(wdata[1]), .DataOut(q[1]), .Result(result[1]),
    .Overflow(ovf[1]), .Busy(busy[1]), .Ready(ready[1]), .fsm_state(st[1])
  );

  // synchronous single-port RAMs with 1- and 2-cycle read latency
  always @(posedge clk) begin
    if (load_req) begin
      for (int k = 0; k < DEPTH; k++) begin
        ram0[k] <= pre[k];
        ram1[k] <= pre[k];
      end
    end else begin
      if (wren[0]) ram0[addr[0]] <= wdata[0];
      if (wren[1]) ram1[addr[1]] <= wdata[1];
    end
    if (rden[0]) q[0] <= ram0[addr[0]];
    if (rden[1]) stage1 <= ram1[addr[1]];
    q[1] <= stage1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every RAM write must match the next expected {address,data}
  task automatic sb_write(input int d, input logic [AW+DW-1:0] got);
    logic [AW+DW-1:0] e;
    int n;
    n = (d == 0) ? exp_q0.size() : exp_q1.size();
    check($sformatf("wr_pending_l%0d", d+1), 32'(n != 0), 32'd1);
    if (n != 0) begin
      if (d == 0) e = exp_q0.pop_front();
      else        e = exp_q1.pop_front();
      check($sformatf("wr_addr_data_l%0d", d+1), 32'(got), 32'(e));
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rden[d] === 1'b1) rd_cnt[d]++;
      if (wren[d] === 1'b1) begin
        wr_cnt[d]++;
        check($sformatf("en_excl_l%0d", d+1), 32'(rden[d]), 32'd0);
        sb_write(d, {addr[d], wdata[d]});
      end
    end
  end

  function automatic logic [DW-1:0] clamp(input longint t);
`ifdef MEM_ACCUM_SATURATE_EN
    return (t > 64'd65535) ? 16'hFFFF : DW'(t);
`else
    return DW'(t);
`endif
  endfunction

  // reference model: true integer sums, then wrap or clamp to DW bits
  task automatic model_job(input logic m, input int b, input int dst, input int ln,
                           input int wr_limit, output logic [DW-1:0] res, output logic ov);
    longint total;
    logic [DW-1:0] w;
    int a, nw;
    total = 0;
    nw = 0;
    for (int i = 0; i < ln; i++) begin
      a = (b + i) % DEPTH;
      total += longint'(mdl[a]);
      w = clamp(total);
      if (m && nw < wr_limit) begin
        exp_q0.push_back({AW'(a), w});
        exp_q1.push_back({AW'(a), w});
        mdl[a] = w;
        nw++;
      end
    end
    res = clamp(total);
    ov  = (total > 64'd65535);
    if (!m && ln > 0 && nw < wr_limit) begin
      exp_q0.push_back({AW'(dst), res});
      exp_q1.push_back({AW'(dst), res});
      mdl[dst] = res;
    end
  endtask

  task automatic load_mem();
    for (int k = 0; k < DEPTH; k++) mdl[k] = pre[k];
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic fill_random();
    for (int k = 0; k < DEPTH; k++) pre[k] = DW'($urandom_range(0, 65535));
  endtask

  task automatic check_ram(input string tag);
    int diff0, diff1;
    diff0 = 0;
    diff1 = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ram0[k] !== mdl[k]) diff0++;
      if (ram1[k] !== mdl[k]) diff1++;
    end
    check({tag, "_ram_l1"}, 32'(diff0), 32'd0);
    check({tag, "_ram_l2"}, 32'(diff1), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_ctl_l%0d", tag, d+1),
            32'({addr[d], rden[d], wren[d], ovf[d], busy[d], ready[d], st[d]}), 32'd0);
      check($sformatf("%s_data_l%0d", tag, d+1), {wdata[d], result[d]}, 32'd0);
    end
  endtask

  // driver: apply a job, optionally pulse a conflicting Start mid-job, then check everything
  task automatic run_job(input string tag, input logic m, input int b, input int dst,
                         input int ln, input int poke);
    logic [DW-1:0] er;
    logic eo;
    int lat [2];
    int rd0 [2];
    int wr0 [2];
    int exp_lat;
    model_job(m, b, dst, ln, 64, er, eo);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(negedge clk);
    mode  = m;
    base  = AW'(b);
    dest  = AW'(dst);
    len   = (AW+1)'(ln);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_busy_acc"}, 32'(busy), 32'd3);
    check({tag, "_ready_acc"}, 32'(ready), 32'd0);
    lat = '{0, 0};
    for (int c = 1; c <= BOUND && (lat[0] == 0 || lat[1] == 0); c++) begin
      @(posedge clk);
      #1;
      if (c == poke + 1) begin
        start = 1'b0;
        mode  = m;
        base  = AW'(b);
        dest  = AW'(dst);
        len   = (AW+1)'(ln);
      end
      for (int d = 0; d < 2; d++) if (ready[d] === 1'b1 && lat[d] == 0) lat[d] = c;
      if (poke > 0 && c == poke) begin
        start = 1'b1;
        mode  = ~m;
        base  = AW'(b + 7);
        dest  = AW'(dst + 3);
        len   = (AW+1)'(ln - 1);
      end
    end
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if (ln == 0)     exp_lat = 1;
      else if (m)      exp_lat = ln * (3 + d) + 1;
      else             exp_lat = ln * (2 + d) + 2;
      check($sformatf("%s_latency_l%0d", tag, d+1), 32'(lat[d]), 32'(exp_lat));
      check($sformatf("%s_result_l%0d", tag, d+1), 32'(result[d]), 32'(er));
      check($sformatf("%s_ovf_l%0d", tag, d+1), 32'(ovf[d]), 32'(eo));
      check($sformatf("%s_busy_l%0d", tag, d+1), 32'(busy[d]), 32'd0);
      check($sformatf("%s_reads_l%0d", tag, d+1), 32'(rd_cnt[d] - rd0[d]), 32'(ln));
      check($sformatf("%s_writes_l%0d", tag, d+1), 32'(wr_cnt[d] - wr0[d]),
            32'(m ? ln : (ln > 0 ? 1 : 0)));
    end
    check({tag, "_sb_left"}, 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    check_ram(tag);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_ready_hold"}, 32'(ready), 32'd3);
  endtask

  // Mode 1 job aborted by reset while the RD_LAT=1 instance waits on element index 2
  task automatic run_abort(input int b, input int ln);
    logic [DW-1:0] er;
    logic eo;
    int rd0 [2];
    int wr0 [2];
    model_job(1'b1, b, 0, ln, 2, er, eo);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(negedge clk);
    mode  = 1'b1;
    base  = AW'(b);
    dest  = '0;
    len   = (AW+1)'(ln);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("abort_wait_state_l1", 32'(st[0]), 32'd2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_zero("abort_rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_idle_en", 32'({st[0], st[1], rden, wren}), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("abort_reads_l1", 32'(rd_cnt[0] - rd0[0]), 32'd3);
    check("abort_reads_l2", 32'(rd_cnt[1] - rd0[1]), 32'd2);
    check("abort_writes_l1", 32'(wr_cnt[0] - wr0[0]), 32'd2);
    check("abort_writes_l2", 32'(wr_cnt[1] - wr0[1]), 32'd2);
    check("abort_sb_left", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    check_ram("abort");
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    mode     = 1'b0;
    base     = '0;
    dest     = '0;
    len      = '0;
    load_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_zero("post_reset");

    // ramp 1..32, total to the last word
    for (int k = 0; k < DEPTH; k++) pre[k] = DW'(k + 1);
    load_mem();
    run_job("ramp", 1'b0, 0, 31, 32, 0);
    check("ramp_total", 32'(result[0]), 32'd528);
    check("ramp_mem", 32'(ram0[31]), 32'h0210);

    // in-place prefix sum wrapping past the top address
    fill_random();
    pre[30] = 16'd5;
    pre[31] = 16'd6;
    pre[0]  = 16'd7;
    load_mem();
    run_job("wrap", 1'b1, 30, int'($urandom_range(0, 31)), 3, 0);
    check("wrap_m31", 32'(ram0[31]), 32'd11);
    check("wrap_m0", 32'(ram1[0]), 32'd18);

    // carry out of the accumulator
    pre[4] = 16'hFFF0;
    pre[5] = 16'h0020;
    load_mem();
    run_job("carry", 1'b0, 4, 10, 2, 0);
`ifdef MEM_ACCUM_SATURATE_EN
    check("carry_mem", 32'(ram0[10]), 32'h0000FFFF);
`else
    check("carry_mem", 32'(ram0[10]), 32'h00000010);
`endif
    check("carry_flag", 32'(ovf), 32'd3);

    // zero-length jobs touch no memory
    run_job("len0_m0", 1'b0, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 0, 0);
    run_job("len0_m1", 1'b1, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 0, 0);

    // Start pulse with different operands while busy
    fill_random();
    load_mem();
    run_job("poke", 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)), 12, 5);

    fill_random();
    load_mem();
    run_abort(20, 6);
    run_job("after_abort", 1'b1, 20, 0, 6, 0);

    for (int j = 0; j < 6; j++) begin
      fill_random();
      load_mem();
      run_job($sformatf("rand%0d", j), 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), int'($urandom_range(1, 32)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
